// File: rtl/iopad_ctrl_pkg.sv
// Shared definitions for the half-duplex iopad sequencer: FSM state encoding
// and the meaning of the pad direction control bit.
package iopad_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX   = 3'd1,
    TURN = 3'd2,
    RX   = 3'd3,
    DONE = 3'd4
  } ctrl_state_e;

  // 1 = pad released (core side tri-stated), 0 = core drives the pad
  localparam logic PAD_DIR_IN  = 1'b1;
  localparam logic PAD_DIR_OUT = 1'b0;

endpackage

// File: rtl/iopad_shift_reg.sv
// WIDTH-bit register with parallel load and shift-right, new bit entering at
// the MSB. Used as the serializer for outgoing words (bit 0 is the serial
// output) and as the deserializer for replies (first bit ends up in bit 0).
module iopad_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  if (WIDTH == 1) begin : g_single
    // A one-bit register simply takes the serial input on a shift
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (load)  q <= load_data;
      else if (shift) q <= serial_in;
    end
  end else begin : g_multi
    // Load has priority; a shift moves everything one place towards bit 0
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (load)  q <= load_data;
      else if (shift) q <= {serial_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iopad_half_duplex_ctrl.sv
// Core-side sequencer for one bidirectional iopad: sends a word LSB first,
// releases the pad for a turnaround gap, collects a reply of the same width
// and holds it on a valid/ready interface until it is taken.
module iopad_half_duplex_ctrl
  import iopad_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             pad_dout,
  output logic             pad_direction,
  input  logic             pad_din,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  ctrl_state_e      state, next_state;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [TW-1:0]    turn_cnt, turn_cnt_next;
  logic             tx_load, tx_shift, rx_shift;
  logic [WIDTH-1:0] tx_q;
  logic             unused_tx_q;

  // Serializer: bit 0 of the register is the pad data. Shifting in zeros means
  // the final TX shift leaves the register empty, so the pad line returns to 0.
  iopad_shift_reg #(.WIDTH(WIDTH)) u_tx_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .shift     (tx_shift),
    .load_data (tx_data),
    .serial_in (1'b0),
    .q         (tx_q)
  );

  // Deserializer: only shifts in RX, so the reply stays frozen in DONE
  iopad_shift_reg #(.WIDTH(WIDTH)) u_rx_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .shift     (rx_shift),
    .load_data ('0),
    .serial_in (pad_din),
    .q         (rx_data)
  );

  assign pad_dout    = tx_q[0];
  assign unused_tx_q = ^tx_q;

  // Next-state, counter and shift-control decode; counters restart on any state change
  always_comb begin
    next_state    = state;
    bit_cnt_next  = bit_cnt;
    turn_cnt_next = turn_cnt;
    tx_load       = 1'b0;
    tx_shift      = 1'b0;
    rx_shift      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          tx_load    = 1'b1;
          next_state = TX;
        end
      end
      TX: begin
        tx_shift = 1'b1;
        if (bit_cnt == BIT_LAST) next_state = TURN;
        else                     bit_cnt_next = bit_cnt + 1'b1;
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) next_state = RX;
        else                       turn_cnt_next = turn_cnt + 1'b1;
      end
      RX: begin
        rx_shift = 1'b1;
        if (bit_cnt == BIT_LAST) next_state = DONE;
        else                     bit_cnt_next = bit_cnt + 1'b1;
      end
      DONE: begin
        if (rx_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (next_state != state) begin
      bit_cnt_next  = '0;
      turn_cnt_next = '0;
    end
  end

  // State, counters and registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      turn_cnt      <= '0;
      pad_direction <= PAD_DIR_IN;
      tx_ready      <= 1'b1;
      rx_valid      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= next_state;
      bit_cnt       <= bit_cnt_next;
      turn_cnt      <= turn_cnt_next;
      pad_direction <= (next_state == TX) ? PAD_DIR_OUT : PAD_DIR_IN;
      tx_ready      <= (next_state == IDLE);
      rx_valid      <= (next_state == DONE);
      busy          <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_iopad_half_duplex_ctrl.sv
// Self-checking bench for iopad_half_duplex_ctrl: a default-sized instance
// driven with directed and random transactions, plus a WIDTH=1/TURN_CYC=1
// instance for the minimum-parameter timing.
module tb_iopad_half_duplex_ctrl;

  localparam int W = 8;
  localparam int T = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         pad_dout;
  logic         pad_direction;
  logic         pad_din;
  logic         busy;

  logic [0:0]   m_tx_data;
  logic         m_tx_valid;
  logic         m_tx_ready;
  logic [0:0]   m_rx_data;
  logic         m_rx_valid;
  logic         m_rx_ready;
  logic         m_pad_dout;
  logic         m_pad_direction;
  logic         m_pad_din;
  logic         m_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  iopad_half_duplex_ctrl #(.WIDTH(W), .TURN_CYC(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .pad_dout      (pad_dout),
    .pad_direction (pad_direction),
    .pad_din       (pad_din),
    .busy          (busy)
  );

  iopad_half_duplex_ctrl #(.WIDTH(1), .TURN_CYC(1)) dut_min (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (m_tx_data),
    .tx_valid      (m_tx_valid),
    .tx_ready      (m_tx_ready),
    .rx_data       (m_rx_data),
    .rx_valid      (m_rx_valid),
    .rx_ready      (m_rx_ready),
    .pad_dout      (m_pad_dout),
    .pad_direction (m_pad_direction),
    .pad_din       (m_pad_din),
    .busy          (m_busy)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the scripted sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One full transaction on the 8-bit instance. The expected pad trace comes
  // straight from the timing rules: W drive cycles carrying word LSB first,
  // T released cycles, W sample edges collecting reply LSB first, then the
  // reply is held until accepted.
  task automatic applyStimulus(input logic [W-1:0] word, input logic [W-1:0] reply,
                               input int stall, input bit poke);
    logic [W-1:0] seen;
    int bad;
    tx_data  = word;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = poke;
    tx_data  = poke ? 8'hFF : 8'($urandom);
    seen = '0;
    bad  = 0;
    for (int k = 0; k < W; k++) begin
      seen[k] = pad_dout;
      if (pad_direction !== 1'b0 || tx_ready !== 1'b0 || busy !== 1'b1 || rx_valid !== 1'b0) bad++;
      rx_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    checkOutput("tx_word", 32'(seen), 32'(word));
    checkOutput("tx_phase", 32'(bad), 32'd0);
    bad = 0;
    for (int t = 0; t < T; t++) begin
      if (pad_direction !== 1'b1 || pad_dout !== 1'b0 || busy !== 1'b1 || rx_valid !== 1'b0) bad++;
      pad_din  = 1'($urandom);
      rx_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    checkOutput("turn_phase", 32'(bad), 32'd0);
    bad = 0;
    for (int j = 0; j < W; j++) begin
      if (pad_direction !== 1'b1 || pad_dout !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0) bad++;
      pad_din  = reply[j];
      rx_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    checkOutput("rx_phase", 32'(bad), 32'd0);
    checkOutput("rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("rx_data", 32'(rx_data), 32'(reply));
    checkOutput("done_ctl", 32'({tx_ready, busy, pad_direction}), 32'b011);
    bad = 0;
    for (int s = 0; s < stall; s++) begin
      rx_ready = 1'b0;
      pad_din  = 1'($urandom);
      @(posedge clk); #1;
      if (rx_valid !== 1'b1 || rx_data !== reply || tx_ready !== 1'b0) bad++;
    end
    checkOutput("stall", 32'(bad), 32'd0);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    checkOutput("accept", 32'({rx_valid, tx_ready, busy, pad_direction}), 32'b0101);
    @(posedge clk); #1;
    checkOutput("idle_after", 32'({busy, tx_ready}), 32'b01);
  endtask

  // Main sequence: reset, directed cases, random traffic, reset mid-TX, minimum parameters
  initial begin
    int bad;
    rst_n      = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    pad_din    = 1'b0;
    m_tx_data  = '0;
    m_tx_valid = 1'b0;
    m_rx_ready = 1'b0;
    m_pad_din  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctl", 32'({pad_direction, pad_dout, tx_ready, rx_valid, busy}), 32'b10100);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({pad_direction, pad_dout, tx_ready, rx_valid, busy} !== 5'b10100) bad++;
    end
    checkOutput("idle_hold", 32'(bad), 32'd0);

    $display("[TB] basic transaction A5 -> 3C");
    applyStimulus(8'hA5, 8'h3C, 0, 1'b0);
    $display("[TB] backpressure 10 cycles");
    applyStimulus(8'hA5, 8'h3C, 10, 1'b0);
    $display("[TB] request during TX ignored");
    applyStimulus(8'h01, 8'($urandom), 0, 1'b1);

    $display("[TB] random transactions");
    for (int n = 0; n < 20; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] reset during TX");
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_drive", 32'(pad_direction), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_release", 32'({pad_direction, pad_dout, busy}), 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset", 32'({tx_ready, rx_valid, busy, pad_direction}), 32'b1001);
    applyStimulus(8'($urandom), 8'h96, 1, 1'b0);

    $display("[TB] minimum parameters");
    m_tx_data  = 1'b1;
    m_tx_valid = 1'b1;
    @(posedge clk); #1;
    m_tx_valid = 1'b0;
    checkOutput("min_tx", 32'({m_pad_direction, m_pad_dout, m_busy}), 32'b011);
    @(posedge clk); #1;
    checkOutput("min_turn", 32'({m_pad_direction, m_pad_dout, m_rx_valid}), 32'b100);
    m_pad_din = 1'b1;
    @(posedge clk); #1;
    checkOutput("min_rx", 32'({m_pad_direction, m_rx_valid}), 32'b10);
    m_pad_din = 1'b0;
    @(posedge clk); #1;
    m_pad_din = 1'b1;
    checkOutput("min_valid", 32'({m_rx_valid, m_rx_data}), 32'b10);
    m_rx_ready = 1'b1;
    @(posedge clk); #1;
    m_rx_ready = 1'b0;
    checkOutput("min_accept", 32'({m_rx_valid, m_tx_ready, m_busy}), 32'b010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
